// File: rtl/maxnet_param.sv
// Parametrised MaxNet winner-take-all engine: iterative lateral inhibition over N channels
// until at most one activation survives or the iteration cap is reached.
module maxnet_param #(
    parameter int unsigned N        = 4,
    parameter int unsigned W        = 16,
    parameter int unsigned FRAC     = 8,
    parameter int unsigned MAX_ITER = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [N*W-1:0]                 x_in,
    input  logic [W-1:0]                   eps,
    output logic                           busy,
    output logic                           done,
    output logic [W-1:0]                   result,
    output logic [$clog2(N)-1:0]           winner,
    output logic                           no_winner,
    output logic                           timeout,
    output logic [$clog2(MAX_ITER+1)-1:0]  iterations
);

    localparam int unsigned IdxW  = $clog2(N);
    localparam int unsigned IterW = $clog2(MAX_ITER + 1);
    localparam int unsigned SumW  = W + $clog2(N);
    localparam int unsigned ProdW = W + SumW;
    localparam int unsigned CntW  = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

    state_e state_q, state_d;

    logic [N-1:0][W-1:0] a_q, a_d;
    logic [W-1:0]        eps_q, eps_d;
    logic [IterW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]        result_q, result_d;
    logic [IdxW-1:0]     winner_q, winner_d;
    logic                no_winner_q, no_winner_d;
    logic                timeout_q, timeout_d;
    logic [IterW-1:0]    iterations_q, iterations_d;

    logic [SumW-1:0]        sum;
    logic [CntW-1:0]        nz;
    logic [W-1:0]           max_val;
    logic [IdxW-1:0]        max_idx;
    logic [N-1:0][SumW-1:0] others;
    logic [N-1:0][ProdW-1:0] thr;
    logic [N-1:0][W-1:0]    a_upd;
    logic                   cap_hit;
    logic                   finish;

    // Population sum and nonzero count of the current activations.
    always_comb begin
        sum = '0;
        nz  = '0;
        for (int i = 0; i < N; i++) begin
            sum = sum + SumW'(a_q[i]);
            nz  = nz + CntW'(a_q[i] != '0);
        end
    end

    // Strict '>' keeps the lowest index on ties.
    always_comb begin
        max_val = a_q[0];
        max_idx = '0;
        for (int i = 1; i < N; i++) begin
            if (a_q[i] > max_val) begin
                max_val = a_q[i];
                max_idx = IdxW'(i);
            end
        end
    end

    // Inhibition term kept at full width so the clamp to zero compares exactly.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            others[i] = sum - SumW'(a_q[i]);
            thr[i]    = (ProdW'(eps_q) * ProdW'(others[i])) >> FRAC;
            if (ProdW'(a_q[i]) >= thr[i]) begin
                a_upd[i] = a_q[i] - thr[i][W-1:0];
            end else begin
                a_upd[i] = '0;
            end
        end
    end

    assign cap_hit = (cnt_q == IterW'(MAX_ITER));
    assign finish  = (nz <= CntW'(1)) || cap_hit;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            a_q          <= '0;
            eps_q        <= '0;
            cnt_q        <= '0;
            result_q     <= '0;
            winner_q     <= '0;
            no_winner_q  <= 1'b0;
            timeout_q    <= 1'b0;
            iterations_q <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            eps_q        <= eps_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            winner_q     <= winner_d;
            no_winner_q  <= no_winner_d;
            timeout_q    <= timeout_d;
            iterations_q <= iterations_d;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        eps_d        = eps_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        winner_d     = winner_q;
        no_winner_d  = no_winner_q;
        timeout_d    = timeout_q;
        iterations_d = iterations_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = x_in;
                    eps_d   = eps;
                    cnt_d   = '0;
                    state_d = StEval;
                end
            end
            StEval: begin
                if (finish) begin
                    result_d     = max_val;
                    winner_d     = max_idx;
                    no_winner_d  = (nz == '0);
                    timeout_d    = (nz > CntW'(1));
                    iterations_d = cnt_q;
                    state_d      = StDone;
                end else begin
                    a_d   = a_upd;
                    cnt_d = cnt_q + IterW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
            end
            StEval: begin
                busy = 1'b1;
            end
            StDone: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign result     = result_q;
    assign winner     = winner_q;
    assign no_winner  = no_winner_q;
    assign timeout    = timeout_q;
    assign iterations = iterations_q;

endmodule

// File: tb/tb_maxnet_param.sv
// Bench for maxnet_param: a 4x16 (FRAC 8) and an 8x24 (FRAC 12) instance checked every cycle
// against a run-to-completion reference of the MaxNet update rule.
module tb_maxnet_param;

    typedef longint unsigned vec_t [8];

    typedef struct packed {
        int              k;
        longint unsigned res;
        int              win;
        bit              nw;
        bit              to;
    } ref_t;

    localparam int Cap = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bit              tstart [2];
    vec_t            tx     [2];
    longint unsigned teps   [2];

    logic [63:0]  x0;
    logic [191:0] x1;
    logic [15:0]  e0;
    logic [23:0]  e1;
    logic         st0, st1;

    logic        busy0, done0, nw0, to0;
    logic [15:0] res0;
    logic [1:0]  win0;
    logic [6:0]  it0;
    logic        busy1, done1, nw1, to1;
    logic [23:0] res1;
    logic [2:0]  win1;
    logic [6:0]  it1;

    logic [63:0] d_busy [2], d_done [2], d_res [2], d_win [2], d_nw [2], d_to [2], d_it [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) x0[i*16 +: 16] = tx[0][i][15:0];
        for (int i = 0; i < 8; i++) x1[i*24 +: 24] = tx[1][i][23:0];
        e0  = teps[0][15:0];
        e1  = teps[1][23:0];
        st0 = tstart[0];
        st1 = tstart[1];
    end

    maxnet_param #(.N(4), .W(16), .FRAC(8), .MAX_ITER(Cap)) dut0 (
        .clk(clk), .rst(rst), .start(st0), .x_in(x0), .eps(e0),
        .busy(busy0), .done(done0), .result(res0), .winner(win0),
        .no_winner(nw0), .timeout(to0), .iterations(it0)
    );

    maxnet_param #(.N(8), .W(24), .FRAC(12), .MAX_ITER(Cap)) dut1 (
        .clk(clk), .rst(rst), .start(st1), .x_in(x1), .eps(e1),
        .busy(busy1), .done(done1), .result(res1), .winner(win1),
        .no_winner(nw1), .timeout(to1), .iterations(it1)
    );

    always_comb begin
        d_busy[0] = 64'(busy0); d_done[0] = 64'(done0); d_res[0] = 64'(res0);
        d_win[0]  = 64'(win0);  d_nw[0]   = 64'(nw0);   d_to[0]  = 64'(to0);
        d_it[0]   = 64'(it0);
        d_busy[1] = 64'(busy1); d_done[1] = 64'(done1); d_res[1] = 64'(res1);
        d_win[1]  = 64'(win1);  d_nw[1]   = 64'(nw1);   d_to[1]  = 64'(to1);
        d_it[1]   = 64'(it1);
    end

    // Reference: run the whole competition with plain integer arithmetic.
    function automatic ref_t ref_run(int n, int frac, vec_t x, longint unsigned e);
        ref_t            r;
        vec_t            a, nxt;
        longint unsigned s, t;
        int              nz;
        a   = x;
        nxt = x;
        r   = '0;
        nz  = 0;
        for (int it = 0; it <= Cap; it++) begin
            nz = 0;
            s  = 0;
            for (int i = 0; i < n; i++) begin
                s += a[i];
                if (a[i] != 0) nz++;
            end
            if (nz <= 1 || r.k == Cap) break;
            for (int i = 0; i < n; i++) begin
                t      = (e * (s - a[i])) >> frac;
                nxt[i] = (a[i] >= t) ? a[i] - t : 0;
            end
            for (int i = 0; i < n; i++) a[i] = nxt[i];
            r.k++;
        end
        for (int i = 0; i < n; i++) begin
            if (a[i] > r.res) begin
                r.res = a[i];
                r.win = i;
            end
        end
        r.nw = (nz == 0);
        r.to = (nz > 1);
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-level model: latency and held outputs derived from the reference result.
    ref_t pred [2];
    ref_t pend [2];
    bit   m_busy [2] = '{0, 0};
    bit   m_done [2] = '{0, 0};
    int   m_left [2] = '{0, 0};
    ref_t m_out  [2] = '{'0, '0};

    always_comb begin
        pred[0] = ref_run(4, 8, tx[0], teps[0]);
        pred[1] = ref_run(8, 12, tx[1], teps[1]);
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_busy[d] <= 1'b0;
                m_done[d] <= 1'b0;
                m_left[d] <= 0;
                m_out[d]  <= '0;
            end else if (!m_busy[d]) begin
                if (tstart[d]) begin
                    m_busy[d] <= 1'b1;
                    m_left[d] <= pred[d].k + 1;
                    pend[d]   <= pred[d];
                end
            end else if (m_done[d]) begin
                m_done[d] <= 1'b0;
                m_busy[d] <= 1'b0;
            end else if (m_left[d] == 1) begin
                m_done[d] <= 1'b1;
                m_left[d] <= 0;
                m_out[d]  <= pend[d];
            end else begin
                m_left[d] <= m_left[d] - 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check($sformatf("busy[%0d]", d), d_busy[d], 64'(m_busy[d]));
            check($sformatf("done[%0d]", d), d_done[d], 64'(m_done[d]));
            check($sformatf("result[%0d]", d), d_res[d], m_out[d].res);
            check($sformatf("winner[%0d]", d), d_win[d], 64'(m_out[d].win));
            check($sformatf("no_winner[%0d]", d), d_nw[d], 64'(m_out[d].nw));
            check($sformatf("timeout[%0d]", d), d_to[d], 64'(m_out[d].to));
            check($sformatf("iterations[%0d]", d), d_it[d], 64'(m_out[d].k));
        end
    end

    // Called just after a rising edge; start is sampled on the next one.
    task automatic start_run(int d, vec_t x, longint unsigned e);
        tx[d]     = x;
        teps[d]   = e;
        tstart[d] = 1'b1;
        @(posedge clk);
        #1 tstart[d] = 1'b0;
    endtask

    // Returns the number of falling edges until done is seen (k+2 for k updates).
    task automatic wait_done(int d, output int c);
        c = 0;
        while (d_done[d] !== 64'd1 && c < 300) begin
            @(negedge clk);
            c++;
        end
        check($sformatf("done_seen[%0d]", d), d_done[d], 64'd1);
    endtask

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v, vz;
        ref_t r;
        int   lat;

        vz = '{0, 0, 0, 0, 0, 0, 0, 0};
        for (int d = 0; d < 2; d++) begin
            tstart[d] = 1'b0;
            tx[d]     = vz;
            teps[d]   = 0;
        end

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", d_busy[0], 64'd0);
        check("rst_result", d_res[0], 64'd0);
        check("rst_iterations", d_it[0], 64'd0);

        // Pin the reference on hand-worked cases.
        v = '{256, 128, 64, 0, 0, 0, 0, 0};
        r = ref_run(4, 8, v, 64);
        check("ref1_k", 64'(r.k), 64'd2);
        check("ref1_res", r.res, 64'd196);
        v = '{256, 256, 0, 0, 0, 0, 0, 0};
        r = ref_run(4, 8, v, 64);
        check("ref2_k", 64'(r.k), 64'd64);
        check("ref2_res", r.res, 64'd3);
        check("ref2_to", 64'(r.to), 64'd1);

        // Two-step convergence.
        v = '{16'h0100, 16'h0080, 16'h0040, 0, 0, 0, 0, 0};
        start_run(0, v, 16'h0040);
        wait_done(0, lat);
        check("t1_latency", 64'(lat), 64'd4);
        check("t1_result", d_res[0], 64'h00C4);
        check("t1_winner", d_win[0], 64'd0);
        check("t1_iter", d_it[0], 64'd2);
        check("t1_flags", {d_nw[0][0], d_to[0][0]}, 64'd0);
        realign();

        // Tie that stalls at 3 and hits the cap.
        v = '{16'h0100, 16'h0100, 0, 0, 0, 0, 0, 0};
        start_run(0, v, 16'h0040);
        wait_done(0, lat);
        check("t2_latency", 64'(lat), 64'd66);
        check("t2_timeout", d_to[0], 64'd1);
        check("t2_result", d_res[0], 64'd3);
        check("t2_winner", d_win[0], 64'd0);
        check("t2_iter", d_it[0], 64'd64);
        realign();

        // All zero.
        start_run(0, vz, 16'h0040);
        wait_done(0, lat);
        check("t3_latency", 64'(lat), 64'd2);
        check("t3_no_winner", d_nw[0], 64'd1);
        check("t3_timeout", d_to[0], 64'd0);
        check("t3_result", d_res[0], 64'd0);
        check("t3_iter", d_it[0], 64'd0);
        realign();

        // Single nonzero.
        v = '{0, 0, 16'h0055, 0, 0, 0, 0, 0};
        start_run(0, v, 16'h0040);
        wait_done(0, lat);
        check("t4_latency", 64'(lat), 64'd2);
        check("t4_result", d_res[0], 64'h0055);
        check("t4_winner", d_win[0], 64'd2);
        check("t4_no_winner", d_nw[0], 64'd0);
        realign();

        // Start held through EVAL and the DONE cycle is ignored.
        v = '{16'h0040, 16'h0100, 16'h0080, 0, 0, 0, 0, 0};
        start_run(0, v, 16'h0040);
        tx[0]     = vz;
        tstart[0] = 1'b1;
        wait_done(0, lat);
        tstart[0] = 1'b0;
        check("t5_result", d_res[0], 64'd196);
        check("t5_winner", d_win[0], 64'd1);
        check("t5_iter", d_it[0], 64'd2);
        realign();
        check("t5_idle_after_done", d_busy[0], 64'd0);

        // Start in the cycle right after DONE is accepted.
        v = '{0, 0, 16'h0055, 0, 0, 0, 0, 0};
        start_run(0, v, 16'h0010);
        wait_done(0, lat);
        check("t6_result", d_res[0], 64'h0055);
        check("t6_winner", d_win[0], 64'd2);
        realign();

        // Reset mid-EVAL aborts and clears.
        v = '{16'h0100, 16'h0100, 0, 0, 0, 0, 0, 0};
        start_run(0, v, 16'h0040);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("t7_busy", d_busy[0], 64'd0);
        check("t7_done", d_done[0], 64'd0);
        check("t7_result", d_res[0], 64'd0);
        check("t7_winner", d_win[0], 64'd0);
        check("t7_iter", d_it[0], 64'd0);
        repeat (3) @(posedge clk);
        #1;
        v = '{16'h0100, 16'h0080, 16'h0040, 0, 0, 0, 0, 0};
        start_run(0, v, 16'h0040);
        wait_done(0, lat);
        check("t7_rerun_result", d_res[0], 64'h00C4);
        check("t7_rerun_iter", d_it[0], 64'd2);
        realign();

        // Wide instance, random activations with eps below 1/7.
        for (int run = 0; run < 8; run++) begin
            for (int i = 0; i < 8; i++) begin
                v[i] = longint'($urandom_range(0, 24'hFFFFFF));
                if ($urandom_range(0, 3) == 0) v[i] = 0;
            end
            start_run(1, v, longint'($urandom_range(64, 580)));
            wait_done(1, lat);
            check("rnd_latency", 64'(lat), 64'(pend[1].k + 2));
            realign();
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d",
                 n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
